// File: rtl/branch_unit_if.sv
// Request/response bundle for the RV32I branch compare unit.
// master = requester (issues branches, consumes results); slave = branch_unit.
interface branch_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_illegal;

    modport master (
        output in_valid, rs1, rs2, funct3, pc, imm, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_illegal
    );

    modport slave (
        input  in_valid, rs1, rs2, funct3, pc, imm, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_illegal
    );
endinterface

// File: rtl/branch_unit.sv
// RV32I branch resolution unit. Operands are compared one nibble per cycle,
// MSB first, stopping at the first differing nibble. Signed compares are
// turned into unsigned ones by flipping bit 31 of both operands at latch time.
module branch_unit (
    input  logic          clk,
    input  logic          rst,
    branch_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_tgt;
    logic [2:0]  r_f3;
    logic [2:0]  r_idx;
    logic        r_out_taken;
    logic        r_out_illegal;
    logic [31:0] r_out_target;

    logic        w_accept;
    logic        w_illegal_in;
    logic        w_signed_in;
    logic [3:0]  w_na;
    logic [3:0]  w_nb;
    logic        w_load;
    logic        w_eq;
    logic        w_lt;
    logic        w_taken;

    assign w_accept     = bus.in_valid && (r_state == IDLE);
    assign w_illegal_in = (bus.funct3[2:1] == 2'b01);
    assign w_signed_in  = (bus.funct3[2:1] == 2'b10);
    assign w_na         = r_a[{r_idx, 2'b00} +: 4];
    assign w_nb         = r_b[{r_idx, 2'b00} +: 4];

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.out_taken   = r_out_taken;
    assign bus.out_target  = r_out_target;
    assign bus.out_illegal = r_out_illegal;

    // State register; reset wins over acceptance and handoff.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state plus the per-nibble verdict; w_load marks the edge that writes a result.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_eq   = 1'b0;
        w_lt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_illegal_in ? DONE : COMPARE;
                    w_load = w_illegal_in;
                end
            end
            COMPARE: begin
                if (w_na != w_nb) begin
                    w_lt   = (w_na < w_nb);
                    w_next = DONE;
                    w_load = 1'b1;
                end else if (r_idx == 3'd0) begin
                    w_eq   = 1'b1;
                    w_next = DONE;
                    w_load = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Map the eq/lt verdict onto the branch type.
    always_comb begin
        w_taken = 1'b0;
        case (r_f3)
            3'b000:         w_taken = w_eq;
            3'b001:         w_taken = !w_eq;
            3'b100, 3'b110: w_taken = w_lt;
            3'b101, 3'b111: w_taken = !w_lt;
            default:        w_taken = 1'b0;
        endcase
    end

    // Operand latch, nibble walk and result registers (results persist after handoff).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a           <= '0;
            r_b           <= '0;
            r_tgt         <= '0;
            r_f3          <= '0;
            r_idx         <= 3'd7;
            r_out_taken   <= 1'b0;
            r_out_illegal <= 1'b0;
            r_out_target  <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= {bus.rs1[31] ^ w_signed_in, bus.rs1[30:0]};
                r_b   <= {bus.rs2[31] ^ w_signed_in, bus.rs2[30:0]};
                r_f3  <= bus.funct3;
                r_tgt <= bus.pc + bus.imm;
                r_idx <= 3'd7;
            end
            if (r_state == COMPARE && !w_load)
                r_idx <= r_idx - 3'd1;
            if (w_load) begin
                if (r_state == IDLE) begin
                    // illegal funct3: result straight from the accepted request
                    r_out_taken   <= 1'b0;
                    r_out_illegal <= 1'b1;
                    r_out_target  <= bus.pc + bus.imm;
                end else begin
                    r_out_taken   <= w_taken;
                    r_out_illegal <= 1'b0;
                    r_out_target  <= r_tgt;
                end
            end
        end
    end
endmodule
